// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned WORDS_DEF   = 8;
    localparam int unsigned MEM_LAT_DEF = 4;
    localparam int unsigned AW          = 16;
    localparam int unsigned DW          = 16;
    localparam int unsigned FW          = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    // Transaction context captured when the grant is decided
    typedef struct packed {
        req_id_e         owner;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
    } xact_t;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin pick between instruction and data requesters.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic    req_i,
    input  logic    req_d,
    input  req_id_e last_served,
    output req_id_e pick_c,
    output logic    any_c
);

    always_comb begin
        any_c  = req_i | req_d;
        pick_c = REQ_I;
        if (req_i && req_d) begin
            pick_c = (last_served == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            pick_c = REQ_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-side block fills and D-side fills/writes onto one pipelined memory port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORDS   = WORDS_DEF,
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          i_grant,
    output logic          d_grant,
    output logic          i_fill_valid,
    output logic          d_fill_valid,
    output logic [FW-1:0] fill_word,
    output logic [DW-1:0] fill_data,
    output logic          i_done,
    output logic          d_done,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_valid
);

    // Fill addressing only has room for word index bits [3:1]
    if (WORDS < 2 || WORDS > 8 || (WORDS & (WORDS - 1)) != 0 || MEM_LAT < 1) begin : g_param_check
        $error("mem_arbiter: WORDS must be a power of 2 in 2..8 and MEM_LAT >= 1");
    end

    localparam int unsigned CW = $clog2(WORDS);

    state_e        state,     state_nxt;
    logic [CW-1:0] issue_cnt, issue_nxt;
    logic [CW-1:0] recv_cnt,  recv_nxt;
    req_id_e       last,      last_nxt;
    xact_t         xact,      xact_nxt;

    req_id_e pick_c;
    logic    any_c;

    arb_rr2 u_arb (
        .req_i       (i_req),
        .req_d       (d_req),
        .last_served (last),
        .pick_c      (pick_c),
        .any_c       (any_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            last      <= REQ_I;
            xact      <= '0;
        end else begin
            state     <= state_nxt;
            issue_cnt <= issue_nxt;
            recv_cnt  <= recv_nxt;
            last      <= last_nxt;
            xact      <= xact_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        issue_nxt    = issue_cnt;
        recv_nxt     = recv_cnt;
        last_nxt     = last;
        xact_nxt     = xact;
        i_grant      = 1'b0;
        d_grant      = 1'b0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        fill_word    = '0;
        fill_data    = '0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        if (state != ST_IDLE) begin
            i_grant = (xact.owner == REQ_I);
            d_grant = (xact.owner == REQ_D);
        end

        case (state)
            ST_IDLE: begin
                if (any_c) begin
                    last_nxt  = pick_c;
                    issue_nxt = '0;
                    recv_nxt  = '0;
                    xact_nxt.owner = pick_c;
                    xact_nxt.wdata = '0;
                    if (pick_c == REQ_D) begin
                        xact_nxt.addr = d_we ? {d_addr[AW-1:1], 1'b0} : d_addr;
                        if (d_we) begin
                            xact_nxt.wdata = d_wdata;
                        end
                        state_nxt = d_we ? ST_WRITE : ST_ISSUE;
                    end else begin
                        xact_nxt.addr = i_addr;
                        state_nxt     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                mem_en    = 1'b1;
                mem_addr  = {xact.addr[AW-1:4], 4'b0} + (AW'(issue_cnt) << 1);
                issue_nxt = issue_cnt + CW'(1);
                if (issue_cnt == CW'(WORDS - 1)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = xact.addr;
                mem_wdata = xact.wdata;
                d_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: ;
        endcase

        // Read returns only count while a fill owns the port
        if ((state == ST_ISSUE || state == ST_DRAIN) && mem_valid) begin
            i_fill_valid = (xact.owner == REQ_I);
            d_fill_valid = (xact.owner == REQ_D);
            fill_word    = FW'(recv_cnt);
            fill_data    = mem_rdata;
            recv_nxt     = recv_cnt + CW'(1);
            if (recv_cnt == CW'(WORDS - 1)) begin
                i_done    = (xact.owner == REQ_I);
                d_done    = (xact.owner == REQ_D);
                state_nxt = ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;

    localparam int unsigned WORDS   = 8;
    localparam int unsigned MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_grant, d_grant, i_fill_valid, d_fill_valid, i_done, d_done;
    logic [2:0]  fill_word;
    logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr, mem_valid;
    logic        stray;

    mem_arbiter #(.WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_grant(i_grant), .d_grant(d_grant),
        .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
        .fill_word(fill_word), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read issued in cycle c returns in cycle c+MEM_LAT, data = addr ^ 5A5A
    logic [16:0] st [MEM_LAT] = '{default: 17'h0};
    logic [16:0] cap = 17'h0;
    always @(negedge clk) cap <= {mem_en & ~mem_wr, mem_addr ^ 16'h5A5A};
    always @(posedge clk) begin
        st[0] <= cap;
        for (int k = 1; k < MEM_LAT; k++) st[k] <= st[k-1];
    end
    assign mem_valid = st[MEM_LAT-1][16] | stray;
    assign mem_rdata = st[MEM_LAT-1][15:0];

    typedef struct { logic d; logic wr; logic [15:0] addr; logic [15:0] wdata; } mem_exp_t;
    typedef struct { logic d; logic [2:0] word; logic [15:0] data; logic last; } ret_exp_t;
    mem_exp_t mem_q [$];
    ret_exp_t ret_q [$];

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [63:0] outs();
        return 64'({i_grant, d_grant, i_fill_valid, d_fill_valid, fill_word, fill_data,
                    i_done, d_done, mem_en, mem_wr, mem_addr, mem_wdata});
    endfunction

    function automatic void push_fill(logic d, logic [15:0] a);
        logic [15:0] ad;
        for (int k = 0; k < WORDS; k++) begin
            ad = (a & 16'hFFF0) + 16'(2 * k);
            mem_q.push_back('{d: d, wr: 1'b0, addr: ad, wdata: 16'h0});
            ret_q.push_back('{d: d, word: 3'(k), data: ad ^ 16'h5A5A, last: (k == WORDS - 1)});
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents a memory op or a return
    always @(negedge clk) begin
        mem_exp_t m;
        ret_exp_t r;
        if (rst_n) begin
            if (mem_en) begin
                if (mem_q.size() == 0) chk("unexpected_mem_en", 1, 0);
                else begin
                    m = mem_q.pop_front();
                    chk("mem_wr", 64'(mem_wr), 64'(m.wr));
                    chk("mem_addr", 64'(mem_addr), 64'(m.addr));
                    chk("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
                    chk("issue_grant", 64'({i_grant, d_grant}), m.d ? 64'd1 : 64'd2);
                    if (m.wr) chk("write_done", 64'({i_done, d_done}), 64'd1);
                end
            end
            if (i_fill_valid || d_fill_valid) begin
                if (ret_q.size() == 0) chk("unexpected_fill", 1, 0);
                else begin
                    r = ret_q.pop_front();
                    chk("fill_owner", 64'({i_fill_valid, d_fill_valid}), r.d ? 64'd1 : 64'd2);
                    chk("fill_word", 64'(fill_word), 64'(r.word));
                    chk("fill_data", 64'(fill_data), 64'(r.data));
                    chk("fill_done", 64'({i_done, d_done}), r.last ? (r.d ? 64'd1 : 64'd2) : 64'd0);
                end
            end else if ((i_done || d_done) && !(mem_en && mem_wr)) begin
                chk("spurious_done", 1, 0);
            end
        end
    end

    task automatic wait_done(input logic d, output int tc);
        bit seen = 0;
        tc = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (d ? d_done : i_done) begin
                seen = 1;
                tc = cyc;
            end
        end
        if (!seen) chk(d ? "d_done_timeout" : "i_done_timeout", 0, 1);
    endtask

    task automatic run_i(input logic [15:0] a, input int n, output int t0, output int td);
        @(posedge clk); #1;
        i_addr = a; i_req = 1'b1; t0 = cyc;
        td = 0;
        for (int k = 0; k < n; k++) wait_done(1'b0, td);
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic run_d(input logic [15:0] a, input logic we, input logic [15:0] wd,
                         input int n, output int t0, output int td);
        @(posedge clk); #1;
        d_addr = a; d_we = we; d_wdata = wd; d_req = 1'b1; t0 = cyc;
        td = 0;
        for (int k = 0; k < n; k++) wait_done(1'b1, td);
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 chk("reset_outputs", outs(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_drained(string name);
        repeat (2) @(negedge clk);
        chk(name, 64'(mem_q.size() + ret_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, td, ti0, tid, tdd0, tdd;
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; stray = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        #2 chk("por_outputs", outs(), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // I-side block fill, base 0x1230
        push_fill(1'b0, 16'h1234);
        run_i(16'h1234, 1, t0, td);
        chk("i_fill_latency", 64'(td - t0), 64'd12);
        check_drained("drain_i_fill");

        // Address change mid-fill must not disturb the latched base
        push_fill(1'b0, 16'h5670);
        fork
            run_i(16'h5670, 1, t0, td);
            begin repeat (3) @(posedge clk); #2 i_addr = 16'hFFF0; end
        join
        check_drained("drain_addr_change");

        // D-side single-word write
        mem_q.push_back('{d: 1'b1, wr: 1'b1, addr: 16'h0040, wdata: 16'hBEEF});
        run_d(16'h0041, 1'b1, 16'hBEEF, 1, t0, td);
        chk("write_latency", 64'(td - t0), 64'd1);
        check_drained("drain_write");

        // Stray mem_valid while idle is ignored
        @(posedge clk); #1 stray = 1'b1;
        @(negedge clk);
        chk("idle_stray_valid", 64'({i_fill_valid, d_fill_valid, i_done, d_done}), 0);
        @(posedge clk); #1 stray = 1'b0;

        // Simultaneous fills after reset: D first, then I after one idle cycle
        do_reset();
        push_fill(1'b1, 16'h3000);
        push_fill(1'b0, 16'h4000);
        fork
            run_d(16'h3000, 1'b0, 16'h0, 1, tdd0, tdd);
            run_i(16'h4000, 1, ti0, tid);
        join
        chk("d_first_latency", 64'(tdd - tdd0), 64'd12);
        chk("i_after_d_latency", 64'(tid - tdd), 64'd13);
        check_drained("drain_tie");

        // Both held for four transactions: D, I, D, I
        push_fill(1'b1, 16'h6008);
        push_fill(1'b0, 16'h7010);
        push_fill(1'b1, 16'h6008);
        push_fill(1'b0, 16'h7010);
        fork
            run_d(16'h6008, 1'b0, 16'h0, 2, tdd0, tdd);
            run_i(16'h7010, 2, ti0, tid);
        join
        chk("rr_last_is_i", 64'(tid > tdd), 64'd1);
        check_drained("drain_rr");

        // Reset in cycle 5 of an I fill; in-flight returns then arrive while idle
        push_fill(1'b0, 16'h2220);
        @(posedge clk); #1;
        i_addr = 16'h2220; i_req = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0; i_req = 1'b0;
        #1 chk("reset_midfill_outputs", outs(), 0);
        mem_q.delete();
        ret_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_reset_stray", 64'({i_fill_valid, d_fill_valid, i_done, d_done, mem_en}), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORDS, default 8, meaning words per block fill (power of 2).
REQ-002 Parameter MEM_LAT, default 4, meaning fixed cycles from mem_en read to mem_valid.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  1  instruction-side block fill request, held until i_done.
REQ-006 i_addr  input  16  fill address; low 4 bits ignored.
REQ-007 d_req  input  1  data-side request, held until d_done.
REQ-008 d_we  input  1  1 = single-word write, 0 = block fill.
REQ-009 d_addr  input  16  data-side address.
REQ-010 d_wdata  input  16  write data.
REQ-011 i_grant, d_grant  output  1 each  high from first issue cycle through the done cycle of the owner's transaction.
REQ-012 i_fill_valid, d_fill_valid  output  1 each  fill_data valid for that requester this cycle.
REQ-013 fill_word  output  3  word index of current fill_data.
REQ-014 fill_data  output  16  mem_rdata forwarded.
REQ-015 i_done, d_done  output  1 each  one-cycle completion pulse.
REQ-016 mem_en, mem_wr  output  1 each  memory enable and write strobe.
REQ-017 mem_addr, mem_wdata  output  16 each  memory address and write data.
REQ-018 mem_rdata  input  16; mem_valid  input  1  pipelined read return.

Function
REQ-019 FSM states IDLE, ISSUE, DRAIN, WRITE; one transaction in flight at a time.
REQ-020 IDLE with exactly one request: grant that requester next cycle.
REQ-021 IDLE with both requesting: round-robin on last_served register; last_served resets to I, so D wins first tie.
REQ-022 Address and write data latched in the IDLE cycle the grant is decided; later input changes ignored.
REQ-023 Fill (i_req, or d_req with d_we=0): ISSUE lasts WORDS cycles, mem_en=1, mem_wr=0, mem_addr={addr[15:4], issue_cnt, 1'b0}, issue_cnt 0..WORDS-1.
REQ-024 After last issue: DRAIN until the WORDS-th mem_valid.
REQ-025 Each mem_valid in ISSUE/DRAIN: owner's fill_valid=1, fill_word=recv_cnt, recv_cnt increments.
REQ-026 Owner's done asserts combinationally with the final fill_valid; next state IDLE.
REQ-027 Fill latency: req sampled at cycle t -> done at t+WORDS+MEM_LAT (12 at defaults).
REQ-028 Write (d_req and d_we=1): WRITE lasts one cycle, mem_en=1, mem_wr=1, mem_addr=latched d_addr with bit0 cleared, mem_wdata=latched d_wdata, d_done=1; next state IDLE.
REQ-029 mem_valid in IDLE or WRITE is ignored; no fill_valid asserted.
REQ-030 Request dropped mid-transaction does not abort; transaction completes and done still pulses.
REQ-031 Requester deasserts req the cycle after done; arbiter re-arbitrates from IDLE, minimum one idle cycle between transactions.
REQ-032 No timeout: missing mem_valid holds DRAIN indefinitely.
REQ-033 Outside ISSUE/WRITE, mem_en=mem_wr=0, mem_addr=mem_wdata=0.

Reset
REQ-034 rst_n low: state IDLE, counters 0, last_served=I, latched address/data 0, all outputs 0, immediately regardless of clock.
REQ-035 Reset mid-fill: in-flight returns after release are ignored (IDLE), no done pulse.

Structure
REQ-036 Shared package holds state enum, WORDS/MEM_LAT defaults, requester-ID encoding (I=0, D=1).
REQ-037 One sub-module: arb_rr2, combinational two-way round-robin pick given both requests and last_served.

Verification
REQ-038 i_req=1, i_addr=0x1234 -> mem_addr 0x1230..0x123E over 8 cycles; eight i_fill_valid, fill_word 0..7; i_done at t+12.
REQ-039 d_req=1, d_we=1, d_addr=0x0041, d_wdata=0xBEEF -> one cycle mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, d_done same cycle.
REQ-040 i_req and d_req (fill) same cycle after reset -> D served first, I granted after D done plus one idle cycle.
REQ-041 Both held continuously for 4 transactions -> grant order D,I,D,I.
REQ-042 rst_n low at cycle 5 of an I fill -> outputs 0 immediately; stray mem_valid after release produces no fill_valid or done.
REQ-043 i_addr changed to 0xFFF0 during fill -> mem_addr continues from latched base.
